// File: rtl/debug_uart_tx_sched_if.sv
// Handshake bundle between the CPU write port, the trace source and the UART TX
// that debug_uart_tx_sched arbitrates; master is the surrounding SoC side.
interface debug_uart_tx_sched_if #(
    parameter int FIFO_AW = 2
);
    logic               cpu_wr_en;
    logic [7:0]         cpu_wr_data;
    logic               cpu_full;
    logic               cpu_overflow;
    logic [FIFO_AW:0]   fifo_level;
    logic               trc_req;
    logic [7:0]         trc_data;
    logic               trc_ack;
    logic               uart_tx_en;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_busy;

    modport master (
        output cpu_wr_en, cpu_wr_data, trc_req, trc_data, uart_tx_busy,
        input  cpu_full, cpu_overflow, fifo_level, trc_ack,
        input  uart_tx_en, uart_tx_data
    );

    modport slave (
        input  cpu_wr_en, cpu_wr_data, trc_req, trc_data, uart_tx_busy,
        output cpu_full, cpu_overflow, fifo_level, trc_ack,
        output uart_tx_en, uart_tx_data
    );
endinterface

// File: rtl/debug_uart_tx_sched.sv
// Shares the debug UART TX between the CPU byte FIFO and the trace source.
// Define DEBUG_UART_TRACE_EN to let the trace port compete (round-robin).
module debug_uart_tx_sched #(
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2,
    parameter int BUSY_TIMEOUT = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    debug_uart_tx_sched_if.slave bus
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [TW-1:0]    wait_cnt;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [FIFO_AW:0] level;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             trc_cand;
    logic             pick_cpu;
    logic             launch;
    logic             pop;
    logic             push;
    logic [7:0]       trc_byte;
    logic             tx_en;
    logic [7:0]       tx_data;
    logic             ack;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

`ifdef DEBUG_UART_TRACE_EN
    logic last_trc;

    assign trc_cand = bus.trc_req;
    assign trc_byte = bus.trc_data;
    // On a tie the source that did not win last time goes next.
    assign pick_cpu = !empty && (!trc_cand || last_trc);
`else
    logic unused_trc;

    assign unused_trc = ^{bus.trc_req, bus.trc_data};
    assign trc_cand   = 1'b0;
    assign trc_byte   = 8'h00;
    assign pick_cpu   = !empty;
`endif

    assign launch = (state == IDLE) && !bus.uart_tx_busy
                    && (!empty || trc_cand);
    assign pop    = launch && pick_cpu;
    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign push   = bus.cpu_wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[FIFO_AW-1:0]] <= bus.cpu_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (bus.cpu_wr_en && !push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            tx_en    <= 1'b0;
            tx_data  <= 8'h00;
            ack      <= 1'b0;
`ifdef DEBUG_UART_TRACE_EN
            last_trc <= 1'b1;
`endif
        end else begin
            tx_en <= 1'b0;
            ack   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        tx_en    <= 1'b1;
                        tx_data  <= pick_cpu ? mem[rd_ptr[FIFO_AW-1:0]]
                                             : trc_byte;
                        ack      <= !pick_cpu;
                        wait_cnt <= '0;
                        state    <= WAIT_BUSY;
`ifdef DEBUG_UART_TRACE_EN
                        last_trc <= !pick_cpu;
`endif
                    end
                end
                WAIT_BUSY: begin
                    // A UART that never raises busy must not stall us forever.
                    if (bus.uart_tx_busy)
                        state <= WAIT_DONE;
                    else if (wait_cnt == TO_LAST)
                        state <= IDLE;
                    else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                WAIT_DONE: begin
                    if (!bus.uart_tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_full     = full;
    assign bus.cpu_overflow = overflow;
    assign bus.fifo_level   = level;
    assign bus.trc_ack      = ack;
    assign bus.uart_tx_en   = tx_en;
    assign bus.uart_tx_data = tx_data;
endmodule

// File: tb/tb_debug_uart_tx_sched.sv
// Bench for debug_uart_tx_sched: directed table, hand sequences for the
// multi-cycle corners, and random traffic against a queue-based model.
module tb_debug_uart_tx_sched;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int TO    = 3;
`ifdef DEBUG_UART_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_uart_tx_sched_if #(.FIFO_AW(AW)) bus ();

    debug_uart_tx_sched #(
        .FIFO_DEPTH(DEPTH),
        .FIFO_AW(AW),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       busy;
        logic       en;
        logic [7:0] d;
        int         lvl;
        logic       full;
        logic       ovf;
    } vec_t;
    vec_t tbl[$];

    // Reference model: queue of bytes plus a notion of "channel in use".
    logic [7:0] mq[$];
    bit         m_ovf, m_en, m_ack, m_active, m_seen, m_last_trc;
    logic [7:0] m_data;
    int         m_age;

    function automatic void model_reset();
        mq.delete();
        m_ovf = 0; m_en = 0; m_ack = 0; m_data = 8'h00;
        m_active = 0; m_seen = 0; m_age = 0; m_last_trc = 1;
    endfunction

    function automatic void model_edge();
        int n = mq.size();
        bit popped = 0;
        bit trc = TR && bus.trc_req;
        m_en = 0;
        m_ack = 0;
        if (!m_active) begin
            if (!bus.uart_tx_busy && (n > 0 || trc)) begin
                if (n > 0 && !(trc && !m_last_trc)) begin
                    m_data = mq.pop_front();
                    popped = 1;
                    m_last_trc = 0;
                end else begin
                    m_data = bus.trc_data;
                    m_ack = 1;
                    m_last_trc = 1;
                end
                m_en = 1; m_active = 1; m_seen = 0; m_age = 0;
            end
        end else if (!m_seen) begin
            if (bus.uart_tx_busy) m_seen = 1;
            else begin
                m_age++;
                if (m_age >= TO) m_active = 0;
            end
        end else if (!bus.uart_tx_busy) begin
            m_active = 0;
        end
        if (bus.cpu_wr_en) begin
            if (n < DEPTH || popped) mq.push_back(bus.cpu_wr_data);
            else m_ovf = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic en, logic [7:0] d, int lvl,
                         logic full, logic ovf, logic ack);
        vectors++;
        if (bus.uart_tx_en !== en || bus.uart_tx_data !== d ||
            bus.fifo_level !== (AW + 1)'(lvl) || bus.cpu_full !== full ||
            bus.cpu_overflow !== ovf || bus.trc_ack !== ack) begin
            miscompares++;
            $display("FAIL %s: got en=%b data=%h lvl=%0d full=%b ovf=%b ack=%b, want en=%b data=%h lvl=%0d full=%b ovf=%b ack=%b",
                     name, bus.uart_tx_en, bus.uart_tx_data, bus.fifo_level,
                     bus.cpu_full, bus.cpu_overflow, bus.trc_ack,
                     en, d, lvl, full, ovf, ack);
        end
    endtask

    task automatic do_reset();
        bus.cpu_wr_en = 0; bus.cpu_wr_data = 0;
        bus.trc_req = 0; bus.trc_data = 0; bus.uart_tx_busy = 0;
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        model_reset();
    endtask

    function automatic void add(logic wr, logic [7:0] wd, logic busy, logic en,
                                logic [7:0] d, int lvl, logic full, logic ovf);
        vec_t v;
        v.wr = wr; v.wd = wd; v.busy = busy; v.en = en;
        v.d = d; v.lvl = lvl; v.full = full; v.ovf = ovf;
        tbl.push_back(v);
    endfunction

    logic [7:0] sent[$];
    logic [7:0] want[$];
    int hold;
    int acks;

    initial begin
        do_reset();
        check("reset", 0, 8'h00, 0, 0, 0, 0);

        // single byte, then 5 writes into a held-busy UART, then timeouts
        add(1, 8'h41, 0, 0, 8'h00, 1, 0, 0);
        add(0, 8'h00, 0, 1, 8'h41, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h41, 0, 0, 0);
        add(0, 8'h00, 0, 0, 8'h41, 0, 0, 0);
        add(1, 8'h10, 1, 0, 8'h41, 1, 0, 0);
        add(1, 8'h11, 1, 0, 8'h41, 2, 0, 0);
        add(1, 8'h12, 1, 0, 8'h41, 3, 0, 0);
        add(1, 8'h13, 1, 0, 8'h41, 4, 1, 0);
        add(1, 8'h14, 1, 0, 8'h41, 4, 1, 1);
        add(0, 8'h00, 0, 1, 8'h10, 3, 0, 1);
        add(0, 8'h00, 1, 0, 8'h10, 3, 0, 1);
        add(0, 8'h00, 0, 0, 8'h10, 3, 0, 1);
        add(0, 8'h00, 0, 1, 8'h11, 2, 0, 1);
        add(0, 8'h00, 1, 0, 8'h11, 2, 0, 1);
        add(0, 8'h00, 0, 0, 8'h11, 2, 0, 1);
        add(0, 8'h00, 0, 1, 8'h12, 1, 0, 1);
        add(0, 8'h00, 1, 0, 8'h12, 1, 0, 1);
        add(0, 8'h00, 0, 0, 8'h12, 1, 0, 1);
        add(0, 8'h00, 0, 1, 8'h13, 0, 0, 1);
        add(0, 8'h00, 1, 0, 8'h13, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h13, 0, 0, 1);
        add(1, 8'h55, 0, 0, 8'h13, 1, 0, 1);
        add(0, 8'h00, 0, 1, 8'h55, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h55, 0, 0, 1);
        add(1, 8'h56, 0, 0, 8'h55, 1, 0, 1);
        add(0, 8'h00, 0, 0, 8'h55, 1, 0, 1);
        add(0, 8'h00, 0, 1, 8'h56, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h56, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h56, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h56, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h56, 0, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            bus.cpu_wr_en = tbl[i].wr;
            bus.cpu_wr_data = tbl[i].wd;
            bus.uart_tx_busy = tbl[i].busy;
            tick();
            check($sformatf("tbl%0d", i), tbl[i].en, tbl[i].d, tbl[i].lvl,
                  tbl[i].full, tbl[i].ovf, 1'b0);
        end

        // full FIFO: write coincides with a pop
        do_reset();
        bus.uart_tx_busy = 1;
        bus.cpu_wr_en = 1;
        for (int i = 0; i < 4; i++) begin
            bus.cpu_wr_data = 8'h30 + 8'(i);
            tick();
        end
        check("fill", 0, 8'h00, 4, 1, 0, 0);
        bus.cpu_wr_data = 8'h34;
        bus.uart_tx_busy = 0;
        tick();
        check("full_pop", 1, 8'h30, 4, 1, 0, 0);
        bus.cpu_wr_en = 0;
        bus.uart_tx_busy = 1;
        tick();
        check("full_pop_after", 0, 8'h30, 4, 1, 0, 0);

        // async reset while in WAIT_DONE with two bytes queued
        do_reset();
        bus.uart_tx_busy = 1;
        bus.cpu_wr_en = 1;
        for (int i = 0; i < 3; i++) begin
            bus.cpu_wr_data = 8'h60 + 8'(i);
            tick();
        end
        bus.cpu_wr_en = 0;
        bus.uart_tx_busy = 0;
        tick();
        check("pre_rst_launch", 1, 8'h60, 2, 0, 0, 0);
        bus.uart_tx_busy = 1;
        tick();
        #2;
        rst_n = 0;
        #1;
        check("async_rst", 0, 8'h00, 0, 0, 0, 0);
        tick();
        rst_n = 1;
        bus.uart_tx_busy = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_quiet", 0, 8'h00, 0, 0, 0, 0);
        end

        // CPU vs trace arbitration with a UART that pulses busy
        do_reset();
        bus.uart_tx_busy = 1;
        bus.cpu_wr_en = 1;
        bus.cpu_wr_data = 8'h20;
        tick();
        bus.cpu_wr_data = 8'h21;
        tick();
        bus.cpu_wr_en = 0;
        bus.trc_req = 1;
        bus.trc_data = 8'hA5;
        bus.uart_tx_busy = 0;
        hold = 0;
        acks = 0;
        sent.delete();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.trc_ack === 1'b1) begin
                acks++;
                vectors++;
                if (bus.uart_tx_en !== 1'b1 || bus.uart_tx_data !== 8'hA5) begin
                    miscompares++;
                    $display("FAIL trc_ack_align: got en=%b data=%h, want en=1 data=a5",
                             bus.uart_tx_en, bus.uart_tx_data);
                end
                bus.trc_req = 0;
            end
            if (bus.uart_tx_en === 1'b1) begin
                sent.push_back(bus.uart_tx_data);
                hold = 2;
            end
            bus.uart_tx_busy = (hold > 0);
            if (hold > 0) hold--;
        end
        bus.trc_req = 0;
        want.delete();
        want.push_back(8'h20);
        if (TR) want.push_back(8'hA5);
        want.push_back(8'h21);
        vectors++;
        if (acks != (TR ? 1 : 0)) begin
            miscompares++;
            $display("FAIL trc_ack_count: got %0d, want %0d", acks, TR ? 1 : 0);
        end
        vectors++;
        if (sent.size() != want.size()) begin
            miscompares++;
            $display("FAIL arb_count: got %0d bytes, want %0d", sent.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                vectors++;
                if (sent[i] !== want[i]) begin
                    miscompares++;
                    $display("FAIL arb_order[%0d]: got %h, want %h", i, sent[i], want[i]);
                end
            end
        end

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            bus.cpu_wr_en = ($urandom_range(0, 2) == 0);
            bus.cpu_wr_data = 8'($urandom);
            if (bus.trc_req) begin
                if (m_ack || $urandom_range(0, 31) == 0) bus.trc_req = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.trc_req = 1;
                bus.trc_data = 8'($urandom);
            end
            bus.uart_tx_busy = ($urandom_range(0, 1) == 0);
            model_edge();
            tick();
            check("rand", m_en, m_data, mq.size(), mq.size() == DEPTH,
                  m_ovf, m_ack);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/debug_uart_tx_sched.md
Name: debug_uart_tx_sched

Overview:
Scheduler that shares the single debug UART transmitter between two requesters. The CPU side writes bytes through the debug UART data register into a small FIFO. A hardware trace source offers one byte at a time with a req/ack handshake. The block sits between the peripheral address decode and the UART TX instance: it drives uart_tx_en/uart_tx_data and observes uart_tx_busy.

Parameters:
FIFO_DEPTH, 4, CPU byte FIFO entries; power of two, minimum 2
FIFO_AW, 2, log2(FIFO_DEPTH); pointer width (level counter is FIFO_AW+1 bits)
BUSY_TIMEOUT, 3, cycles to wait for uart_tx_busy to rise after a launch before giving up

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_wr_en  in  1  one-cycle strobe: CPU write to debug UART data register
cpu_wr_data  in  8  byte to transmit
cpu_full  out  1  FIFO full; read back as UART status busy bit
cpu_overflow  out  1  sticky: a CPU byte was dropped
fifo_level  out  FIFO_AW+1  current FIFO occupancy
trc_req  in  1  trace byte offered; held until trc_ack
trc_data  in  8  trace byte, stable while trc_req=1
trc_ack  out  1  one-cycle pulse: trace byte taken
uart_tx_en  out  1  one-cycle start pulse to UART TX
uart_tx_data  out  8  byte to UART TX, valid while uart_tx_en=1
uart_tx_busy  in  1  UART TX busy

Behaviour:
- Reset (async, rst_n=0): FIFO empty, fifo_level=0, cpu_full=0, cpu_overflow=0, trc_ack=0, uart_tx_en=0, uart_tx_data=0, state=IDLE, last_grant=TRACE (so the CPU wins the first tie).
- All outputs are registered; cpu_full and fifo_level are derived from registered pointers.
- FIFO write: cpu_wr_en=1 and not full -> byte stored, level+1.
- Write while full: the byte is dropped and cpu_overflow is set; overflow clears only on reset.
- Write while full with a pop in the same cycle: the byte is accepted and level is unchanged.
- Write and pop on an empty FIFO in the same cycle cannot occur, because pop requires the FIFO to be non-empty at the clock edge.
- Pointers wrap modulo FIFO_DEPTH.
- State IDLE: if uart_tx_busy=0 and a candidate exists (FIFO non-empty, or trc_req=1 when trace is enabled), then at the edge:
  - choose the source: the only candidate, or, if both, the source opposite last_grant (round-robin);
  - register uart_tx_data and set uart_tx_en=1;
  - if CPU: pop the FIFO; if TRACE: trc_ack=1;
  - update last_grant and go to WAIT_BUSY.
- State IDLE with uart_tx_busy=1 or no candidate: stay in IDLE.
- State WAIT_BUSY: uart_tx_en and trc_ack return to 0.
  - uart_tx_busy=1 -> WAIT_DONE.
  - After BUSY_TIMEOUT cycles without busy -> IDLE (treat the byte as sent).
- State WAIT_DONE: uart_tx_busy=0 -> IDLE.
- Minimum spacing between uart_tx_en pulses is 3 cycles; there are never back-to-back pulses.
- Latency: CPU write at edge N into an empty FIFO with an idle UART -> uart_tx_en=1 after edge N+1.
- trc_req deasserted before ack: no ack is issued and no error is raised.
- trc_ack is never asserted without trc_req=1 sampled at the same edge.
- Reset mid-transfer: everything returns to reset values immediately; FIFO contents are lost.

Optional Feature:
DEBUG_UART_TRACE_EN:
- Defined: the trace port arbitrates as above.
- Undefined: trc_req and trc_data are ignored, trc_ack is held at 0, the CPU FIFO is the only source, and last_grant logic is removed. Ports remain present in both builds.

Test Plan:
- Reset, then CPU writes 0x41 with UART idle -> uart_tx_en pulse after 1 cycle with data 0x41; fifo_level 1->0.
- 5 CPU writes (0x10..0x14) while uart_tx_busy is held at 1 -> cpu_full=1 after 4, 0x14 dropped, cpu_overflow=1; release busy -> 0x10..0x13 sent in order.
- FIFO holds 0x20,0x21 and trc_req=1 with trc_data=0xA5, busy pulses model UART -> transmit order 0x20, 0xA5, 0x21; trc_ack is one cycle and aligned with its uart_tx_en.
- Launch with uart_tx_busy never rising -> return to IDLE after BUSY_TIMEOUT=3 cycles; next byte launches.
- FIFO full, and a CPU write coincides with a pop -> byte accepted, level stays 4, cpu_overflow stays 0.
- rst_n low during WAIT_DONE with 2 bytes queued -> all outputs go to reset values asynchronously, fifo_level=0, no uart_tx_en after release.
